// File: rtl/ArgParser_PKG.sv
// Argument parser FSM states and the decimal fixed-point scale table.
package ArgParser_PKG;

    localparam int unsigned MAX_FRAC_DIGITS = 4;
    localparam int unsigned SCALE_W         = 14;

    typedef logic [SCALE_W-1:0] scale_t;

    typedef enum logic [3:0] {
        IDLE, REQ, WAIT_RD, DECODE, SIGN, INT, FRAC, SKIP, FINISH
    } state_t;

    localparam scale_t SCALE_TABLE [MAX_FRAC_DIGITS+1] = '{
        14'd1, 14'd10, 14'd100, 14'd1000, 14'd10000
    };

    // 10^k lookup; k beyond the table clamps to the largest entry
    function automatic scale_t pow10(input logic [2:0] k);
        pow10 = SCALE_TABLE[MAX_FRAC_DIGITS];
        for (int unsigned i = 0; i <= MAX_FRAC_DIGITS; i++) begin
            if (k == 3'(i)) pow10 = SCALE_TABLE[i];
        end
    endfunction

endpackage

// File: rtl/Char_PKG.sv
// Shared ASCII character type, code points and classifiers.
package Char_PKG;

    typedef logic [7:0] Char_t;

    localparam Char_t CH_NL    = 8'h0A;
    localparam Char_t CH_SPACE = 8'h20;
    localparam Char_t CH_LPAR  = 8'h28;
    localparam Char_t CH_RPAR  = 8'h29;
    localparam Char_t CH_MINUS = 8'h2D;
    localparam Char_t CH_DOT   = 8'h2E;
    localparam Char_t CH_0     = 8'h30;
    localparam Char_t CH_SEMI  = 8'h3B;

    function automatic logic is_digit(input Char_t c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_letter(input Char_t c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

endpackage

// File: rtl/FixedPointAccumulator.sv
// Decimal digit accumulator with fraction scaling, sign and saturation.
module FixedPointAccumulator
    import ArgParser_PKG::*;
#(
    parameter int unsigned NUM_BITS    = 16,
    parameter int unsigned FRAC_DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_neg,
    input  logic                i_int_push,
    input  logic                i_frac_push,
    input  logic [3:0]          i_digit,
    output logic [NUM_BITS-1:0] o_value_c,
    output logic                o_too_big_c
);

    localparam int unsigned ACC_W = 2 * NUM_BITS;
    localparam int unsigned MAC_W = ACC_W + 4;
    localparam int unsigned SCL_W = ACC_W + SCALE_W;
    localparam int unsigned CNT_W = 3;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_fcnt;
    logic             r_neg;

    logic [MAC_W-1:0]    w_mac;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_frac_room;
    logic [SCL_W-1:0]    w_scaled;
    logic [SCL_W-1:0]    w_limit;
    logic [NUM_BITS-1:0] w_mag;

    // acc*10+d with sticky saturation: once all-ones it stays all-ones
    assign w_mac       = MAC_W'(r_acc) * MAC_W'(10) + MAC_W'(i_digit);
    assign w_acc_next  = (|w_mac[MAC_W-1:ACC_W]) ? '1 : w_mac[ACC_W-1:0];
    assign w_frac_room = r_fcnt < CNT_W'(FRAC_DIGITS);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc  <= '0;
            r_fcnt <= '0;
            r_neg  <= 1'b0;
        end else begin
            if (i_neg) r_neg <= 1'b1;
            if (i_int_push) begin
                r_acc <= w_acc_next;
            end else if (i_frac_push && w_frac_room) begin
                r_acc  <= w_acc_next;
                r_fcnt <= r_fcnt + CNT_W'(1);
            end
        end
    end

    // Missing fraction digits are zero-padded by scaling up
    assign w_scaled    = SCL_W'(r_acc) * SCL_W'(pow10(CNT_W'(FRAC_DIGITS) - r_fcnt));
    assign w_limit     = r_neg ? (SCL_W'(1) << (NUM_BITS - 1))
                               : ((SCL_W'(1) << (NUM_BITS - 1)) - SCL_W'(1));
    assign o_too_big_c = w_scaled > w_limit;
    assign w_mag       = w_scaled[NUM_BITS-1:0];

    always_comb begin
        o_value_c = r_neg ? (~w_mag + NUM_BITS'(1)) : w_mag;
        if (o_too_big_c) begin
            o_value_c = r_neg ? {1'b1, {(NUM_BITS-1){1'b0}}} : {1'b0, {(NUM_BITS-1){1'b1}}};
        end
    end

endmodule

// File: rtl/multi_arg_parser.sv
// Parses one line of "<title><signed decimal>" fields into fixed-point slots.
// Optional ARG_PARSER_COMMENT_SKIP_EN: ';' comments to newline, '(' ... ')' comments.
module multi_arg_parser
    import Char_PKG::*;
    import ArgParser_PKG::*;
#(
    parameter int unsigned NUM_BITS    = 16,
    parameter int unsigned FRAC_DIGITS = 2,
    parameter int unsigned NUM_ARGS    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         trigger,
    output logic                         rdy,
    output logic                         done,
    output logic                         rd_trigger,
    input  logic                         rd_rdy,
    input  logic                         rd_done,
    input  logic                         is_empty,
    input  logic [7:0]                   char_in,
    input  logic [8*NUM_ARGS-1:0]        arg_titles,
    output logic [NUM_BITS*NUM_ARGS-1:0] args,
    output logic [NUM_ARGS-1:0]          arg_found,
    output logic [NUM_ARGS-1:0]          arg_too_big,
    output logic                         success,
    output logic                         is_newline
);

    localparam int unsigned SLOT_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

    state_t                      r_state;
    state_t                      r_ctx;
    Char_t                       r_char;
    logic                        r_char_vld;
    logic [SLOT_W-1:0]           r_slot;
    logic                        r_err;
    logic                        r_rdy;
    logic                        r_done;
    logic                        r_rd_trig;
    logic [NUM_BITS*NUM_ARGS-1:0] r_args;
    logic [NUM_ARGS-1:0]         r_found;
    logic [NUM_ARGS-1:0]         r_big;
    logic                        r_success;
    logic                        r_newline;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
    logic                        r_cmt;
    Char_t                       r_cmt_end;
    logic                        w_cmt_set;
    logic                        w_cmt_keep;
    Char_t                       w_cmt_end;
`endif

    state_t              w_next;
    logic                w_idle, w_commit, w_err, w_nl, w_finish, w_sel, w_skip_plain;
    logic                w_acc_clr, w_acc_neg, w_acc_int, w_acc_frac;
    logic                w_match;
    logic [SLOT_W-1:0]   w_match_idx;
    logic                w_is_digit, w_is_letter, w_term;
    logic [3:0]          w_digit;
    logic [NUM_BITS-1:0] w_value;
    logic                w_too_big;

    assign w_is_digit  = is_digit(r_char);
    assign w_is_letter = is_letter(r_char);
    assign w_term      = (r_char == CH_SPACE) || w_is_letter || (r_char == CH_NL);
    assign w_digit     = 4'(r_char - CH_0);

    // Title lookup; descending loop so the lowest matching slot wins
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = int'(NUM_ARGS) - 1; i >= 0; i--) begin
            if (r_char == arg_titles[8*i +: 8]) begin
                w_match     = 1'b1;
                w_match_idx = SLOT_W'(i);
            end
        end
    end

    // Per-character decode: actions for the current context plus the next context
    always_comb begin
        w_next       = r_state;
        w_idle       = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_nl         = 1'b0;
        w_finish     = 1'b0;
        w_sel        = 1'b0;
        w_skip_plain = 1'b1;
        w_acc_clr    = 1'b0;
        w_acc_neg    = 1'b0;
        w_acc_int    = 1'b0;
        w_acc_frac   = 1'b0;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
        w_cmt_set    = 1'b0;
        w_cmt_keep   = 1'b0;
        w_cmt_end    = r_cmt_end;
`endif
        case (r_state)
            IDLE:   w_acc_clr = trigger;
            DECODE: w_idle = 1'b1;
            SIGN: begin
                if (r_char == CH_MINUS) begin
                    w_acc_neg = 1'b1;
                end else if (w_is_digit) begin
                    w_acc_int = 1'b1;
                    w_next    = INT;
                end else if (w_term) begin
                    w_commit = 1'b1;
                    w_idle   = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            INT: begin
                if (w_is_digit) begin
                    w_acc_int = 1'b1;
                end else if (r_char == CH_DOT) begin
                    w_next = FRAC;
                end else if (w_term) begin
                    w_commit = 1'b1;
                    w_idle   = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            FRAC: begin
                if (w_is_digit) begin
                    w_acc_frac = 1'b1;
                end else if (w_term) begin
                    w_commit = 1'b1;
                    w_idle   = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            SKIP: begin
`ifdef ARG_PARSER_COMMENT_SKIP_EN
                if (r_cmt) begin
                    w_skip_plain = 1'b0;
                    if (r_char == r_cmt_end) begin
                        if (r_char == CH_NL) w_idle = 1'b1;
                        else                 w_next = DECODE;
                    end else begin
                        w_cmt_keep = 1'b1;
                    end
                end
`endif
                if (w_skip_plain && !(w_is_digit || r_char == CH_DOT || r_char == CH_MINUS)) begin
                    w_idle = 1'b1;
                end
            end
            default: ;
        endcase

        // Idle-context rules, also applied to the character that ended a field
        if (w_idle) begin
            w_next = DECODE;
            if (r_char == CH_SPACE) begin
                w_next = DECODE;
            end else if (w_is_letter) begin
                if (w_match) begin
                    w_sel     = 1'b1;
                    w_acc_clr = 1'b1;
                    w_next    = SIGN;
                end else begin
                    w_next = SKIP;
                end
            end else if (r_char == CH_NL) begin
                w_nl     = 1'b1;
                w_finish = 1'b1;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
            end else if (r_char == CH_SEMI) begin
                w_cmt_set = 1'b1;
                w_cmt_end = CH_NL;
                w_next    = SKIP;
            end else if (r_char == CH_LPAR) begin
                w_cmt_set = 1'b1;
                w_cmt_end = CH_RPAR;
                w_next    = SKIP;
`endif
            end else begin
                w_err = 1'b1;
            end
        end
    end

    FixedPointAccumulator #(
        .NUM_BITS    (NUM_BITS),
        .FRAC_DIGITS (FRAC_DIGITS)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (clk_en & w_acc_clr),
        .i_neg       (clk_en & w_acc_neg),
        .i_int_push  (clk_en & w_acc_int),
        .i_frac_push (clk_en & w_acc_frac),
        .i_digit     (w_digit),
        .o_value_c   (w_value),
        .o_too_big_c (w_too_big)
    );

    // Main FSM; pulses drop every clock, state only moves on enabled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctx      <= DECODE;
            r_char     <= '0;
            r_char_vld <= 1'b0;
            r_slot     <= '0;
            r_err      <= 1'b0;
            r_rdy      <= 1'b1;
            r_done     <= 1'b0;
            r_rd_trig  <= 1'b0;
            r_args     <= '0;
            r_found    <= '0;
            r_big      <= '0;
            r_success  <= 1'b0;
            r_newline  <= 1'b0;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
            r_cmt      <= 1'b0;
            r_cmt_end  <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_rd_trig <= 1'b0;
            if (r_state == WAIT_RD && rd_done) begin
                r_char     <= char_in;
                r_char_vld <= 1'b1;
            end
            if (clk_en) begin
                case (r_state)
                    IDLE: begin
                        if (trigger) begin
                            r_rdy     <= 1'b0;
                            r_ctx     <= DECODE;
                            r_err     <= 1'b0;
                            r_args    <= '0;
                            r_found   <= '0;
                            r_big     <= '0;
                            r_success <= 1'b0;
                            r_newline <= 1'b0;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
                            r_cmt     <= 1'b0;
`endif
                            r_state   <= REQ;
                        end
                    end
                    REQ: begin
                        if (rd_rdy) begin
                            if (is_empty) begin
                                r_state <= FINISH;
                            end else begin
                                r_rd_trig <= 1'b1;
                                r_state   <= WAIT_RD;
                            end
                        end
                    end
                    WAIT_RD: begin
                        if (rd_done || r_char_vld) begin
                            r_char_vld <= 1'b0;
                            r_state    <= r_ctx;
                        end
                    end
                    DECODE, SIGN, INT, FRAC, SKIP: begin
                        r_ctx   <= w_next;
                        r_state <= w_finish ? FINISH : REQ;
                        if (w_err) r_err <= 1'b1;
                        if (w_nl)  r_newline <= 1'b1;
                        if (w_sel) r_slot <= w_match_idx;
`ifdef ARG_PARSER_COMMENT_SKIP_EN
                        r_cmt <= w_cmt_set | (r_cmt & w_cmt_keep);
                        if (w_cmt_set) r_cmt_end <= w_cmt_end;
`endif
                        if (w_commit) begin
                            r_args[int'(r_slot)*NUM_BITS +: NUM_BITS] <= w_value;
                            r_found[r_slot] <= 1'b1;
                            r_big[r_slot]   <= w_too_big;
                            if (r_found[r_slot]) r_err <= 1'b1;
                        end
                    end
                    FINISH: begin
                        r_success <= (|r_found) & ~(|r_big) & ~r_err;
                        r_done    <= 1'b1;
                        r_rdy     <= 1'b1;
                        r_state   <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rdy         = r_rdy;
    assign done        = r_done;
    assign rd_trigger  = r_rd_trig;
    assign args        = r_args;
    assign arg_found   = r_found;
    assign arg_too_big = r_big;
    assign success     = r_success;
    assign is_newline  = r_newline;

endmodule

// File: tb/tb_multi_arg_parser.sv
// Directed table-driven bench for multi_arg_parser (16-bit, 2 fraction digits, 4 slots).
module tb_multi_arg_parser;

    logic        clk, reset, clk_en, trigger;
    logic        rdy, done, rd_trigger;
    logic        rd_rdy, rd_done, is_empty;
    logic [7:0]  char_in;
    logic [31:0] arg_titles;
    logic [63:0] args;
    logic [3:0]  arg_found, arg_too_big;
    logic        success, is_newline;

    multi_arg_parser dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
        .rdy(rdy), .done(done), .rd_trigger(rd_trigger),
        .rd_rdy(rd_rdy), .rd_done(rd_done), .is_empty(is_empty),
        .char_in(char_in), .arg_titles(arg_titles), .args(args),
        .arg_found(arg_found), .arg_too_big(arg_too_big),
        .success(success), .is_newline(is_newline)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [127:0] text;
        int           len;
        logic [31:0]  titles;
        logic [63:0]  exp_args;
        logic [3:0]   exp_found;
        logic [3:0]   exp_big;
        logic         exp_succ;
        logic         exp_nl;
    } vec_t;

    localparam int NV = 15;
    localparam logic [31:0] T_DEF = 32'h465A5958; // slots X,Y,Z,F

    vec_t         vecs [NV];
    logic [127:0] cur_text;
    int           cur_len;
    int           idx;
    int           n_checks = 0;
    int           n_errors = 0;

    // Character source: one char per rd_trigger, delivered two negedges later
    initial begin
        rd_rdy  = 1'b1;
        rd_done = 1'b0;
        char_in = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_trigger) begin
                rd_rdy = 1'b0;
                @(negedge clk);
                char_in = cur_text[8*(cur_len-1-idx) +: 8];
                rd_done = 1'b1;
                @(negedge clk);
                rd_done  = 1'b0;
                idx      = idx + 1;
                is_empty = (idx >= cur_len);
                rd_rdy   = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_parse(input logic [127:0] t, input int n, input logic [31:0] ttl);
        cur_text   = t;
        cur_len    = n;
        idx        = 0;
        is_empty   = (n == 0);
        arg_titles = ttl;
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, " done"}, 64'(done), 64'd1);
    endtask

    task automatic chk_all_clear(input string name);
        chk({name, " rdy"}, 64'(rdy), 64'd1);
        chk({name, " done"}, 64'(done), 64'd0);
        chk({name, " rd_trigger"}, 64'(rd_trigger), 64'd0);
        chk({name, " args"}, args, 64'd0);
        chk({name, " found"}, 64'(arg_found), 64'd0);
        chk({name, " too_big"}, 64'(arg_too_big), 64'd0);
        chk({name, " success"}, 64'(success), 64'd0);
        chk({name, " newline"}, 64'(is_newline), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{"X12.5 Y-3\n",   10, T_DEF, 64'h0000_0000_FED4_04E2, 4'b0011, 4'b0000, 1'b1, 1'b1};
        vecs[1]  = '{"X400 Y-400\n",  11, T_DEF, 64'h0000_0000_8000_7FFF, 4'b0011, 4'b0011, 1'b0, 1'b1};
        vecs[2]  = '{"G1 X5.678\n",   10, T_DEF, 64'h0000_0000_0000_0237, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[3]  = '{"",               0, T_DEF, 64'h0,                   4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[4]  = '{"X327.67\n",      8, T_DEF, 64'h0000_0000_0000_7FFF, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[5]  = '{"X-327.68\n",     9, T_DEF, 64'h0000_0000_0000_8000, 4'b0001, 4'b0000, 1'b1, 1'b1};
        vecs[6]  = '{"X327.68\n",      8, T_DEF, 64'h0000_0000_0000_7FFF, 4'b0001, 4'b0001, 1'b0, 1'b1};
        vecs[7]  = '{"X4294967301\n", 12, T_DEF, 64'h0000_0000_0000_7FFF, 4'b0001, 4'b0001, 1'b0, 1'b1};
        vecs[8]  = '{"X1 X2\n",        6, T_DEF, 64'h0000_0000_0000_00C8, 4'b0001, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{"X1 ?\n",         5, T_DEF, 64'h0000_0000_0000_0064, 4'b0001, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{"A5\n",           3, 32'h43414151, 64'h0000_0000_01F4_0000, 4'b0010, 4'b0000, 1'b1, 1'b1};
`ifdef ARG_PARSER_COMMENT_SKIP_EN
        vecs[11] = '{"X1 ;Y2\n",       7, T_DEF, 64'h0000_0000_0000_0064, 4'b0001, 4'b0000, 1'b1, 1'b1};
`else
        vecs[11] = '{"X1 ;Y2\n",       7, T_DEF, 64'h0000_0000_00C8_0064, 4'b0011, 4'b0000, 1'b0, 1'b1};
`endif
        vecs[12] = '{"F-0.05 Z7\n",   10, T_DEF, 64'hFFFB_02BC_0000_0000, 4'b1100, 4'b0000, 1'b1, 1'b1};
        vecs[13] = '{"Y-\n",           3, T_DEF, 64'h0,                   4'b0010, 4'b0000, 1'b1, 1'b1};
        vecs[14] = '{"X1.2.\n",        6, T_DEF, 64'h0000_0000_0000_0078, 4'b0001, 4'b0000, 1'b0, 1'b1};

        reset      = 1'b1;
        clk_en     = 1'b1;
        trigger    = 1'b0;
        is_empty   = 1'b0;
        arg_titles = T_DEF;
        cur_text   = '0;
        cur_len    = 0;
        idx        = 0;
        repeat (3) @(negedge clk);
        chk_all_clear("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            start_parse(vecs[i].text, vecs[i].len, vecs[i].titles);
            wait_done($sformatf("v%0d", i));
            chk($sformatf("v%0d args", i), args, vecs[i].exp_args);
            chk($sformatf("v%0d found", i), 64'(arg_found), 64'(vecs[i].exp_found));
            chk($sformatf("v%0d too_big", i), 64'(arg_too_big), 64'(vecs[i].exp_big));
            chk($sformatf("v%0d success", i), 64'(success), 64'(vecs[i].exp_succ));
            chk($sformatf("v%0d newline", i), 64'(is_newline), 64'(vecs[i].exp_nl));
            chk($sformatf("v%0d rdy", i), 64'(rdy), 64'd1);
            repeat (4) @(negedge clk);
        end

        // done is a single-cycle pulse and results hold afterwards
        start_parse("Z7\n", 3, T_DEF);
        wait_done("pulse");
        @(negedge clk);
        chk("pulse done low", 64'(done), 64'd0);
        chk("pulse hold args", args, 64'h0000_02BC_0000_0000);
        chk("pulse hold success", 64'(success), 64'd1);

        // trigger ignored while idle-but-disabled
        clk_en  = 1'b0;
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        clk_en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("clk_en rdy", 64'(rdy), 64'd1);
        chk("clk_en hold success", 64'(success), 64'd1);

        // reset clears held results
        reset = 1'b1;
        @(negedge clk);
        chk_all_clear("reset held");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // trigger while busy is ignored
        start_parse(vecs[0].text, vecs[0].len, T_DEF);
        repeat (10) @(negedge clk);
        chk("busy rdy", 64'(rdy), 64'd0);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done("busy");
        chk("busy args", args, vecs[0].exp_args);
        chk("busy found", 64'(arg_found), 64'b0011);
        repeat (4) @(negedge clk);

        // reset in the middle of an integer field, then a fresh parse
        start_parse("X12", 3, T_DEF);
        begin
            int k;
            k = 0;
            while (idx < 2 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("mid idx reached", 64'(idx >= 2), 64'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_clear("mid reset");
        repeat (6) @(negedge clk);
        start_parse("Z7\n", 3, T_DEF);
        wait_done("after reset");
        chk("after reset args", args, 64'h0000_02BC_0000_0000);
        chk("after reset found", 64'(arg_found), 64'b0100);
        chk("after reset success", 64'(success), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
